// File: rtl/axi_grid_xni_link_arb.sv
// Round-robin, packet-locking arbiter for one grid network-interface injection link.
// Multi-beat packets hold the link until their last beat. The output stage is a
// registered valid/ready slot. A beat watchdog cuts off runaway packets and
// raises a sticky error.
module axi_grid_xni_link_arb #(
  parameter int unsigned NUM_REQ   = 4,
  parameter int unsigned FLIT_W    = 64,
  parameter int unsigned MAX_BEATS = 256,
  parameter int unsigned SRC_W     = $clog2(NUM_REQ)
) (
  input  logic                      clk_i,
  input  logic                      srst_i,
  input  logic [NUM_REQ-1:0]        req_valid_i,
  input  logic [NUM_REQ*FLIT_W-1:0] req_flit_i,
  input  logic [NUM_REQ-1:0]        req_last_i,
  output logic [NUM_REQ-1:0]        req_ready_o,
  output logic                      out_valid_o,
  output logic [FLIT_W-1:0]         out_flit_o,
  output logic                      out_last_o,
  output logic [SRC_W-1:0]          out_src_o,
  input  logic                      out_ready_i,
  output logic                      busy_o,
  output logic                      err_o,
  input  logic                      err_clr_i
);

  localparam int unsigned CNT_W = $clog2(MAX_BEATS + 1);

  localparam logic [0:0] ST_IDLE   = 1'b0;
  localparam logic [0:0] ST_LOCKED = 1'b1;

  localparam logic [SRC_W-1:0] LAST_IDX = SRC_W'(NUM_REQ - 1);
  // Beat count at which the next accepted non-last beat is beat MAX_BEATS.
  localparam logic [CNT_W-1:0] WD_CNT   = CNT_W'(MAX_BEATS - 1);

  logic [0:0]        state_q, state_d;
  logic [SRC_W-1:0]  ptr_q, ptr_d;
  logic [SRC_W-1:0]  owner_q, owner_d;
  logic [CNT_W-1:0]  beat_cnt_q, beat_cnt_d;
  logic              err_q, err_d;
  logic              busy_q, busy_d;

  logic              out_valid_q, out_valid_d;
  logic [FLIT_W-1:0] out_flit_q, out_flit_d;
  logic              out_last_q, out_last_d;
  logic [SRC_W-1:0]  out_src_q, out_src_d;

  logic              reg_free;
  logic              grant_found;
  logic [SRC_W-1:0]  grant_idx;
  int unsigned       scan_sum;
  logic [SRC_W-1:0]  scan_idx;

  logic              acc_valid;
  logic [SRC_W-1:0]  acc_idx;
  logic [FLIT_W-1:0] acc_flit;
  logic              acc_last;
  logic              wd_fire;

  function automatic logic [SRC_W-1:0] wrap_inc(input logic [SRC_W-1:0] k);
    return (k == LAST_IDX) ? '0 : k + SRC_W'(1);
  endfunction

  assign reg_free = ~out_valid_q | out_ready_i;

  // Round-robin search: first valid requester at or above ptr, modulo NUM_REQ.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    scan_sum    = 0;
    scan_idx    = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      scan_sum = 32'(ptr_q) + i;
      if (scan_sum >= NUM_REQ) begin
        scan_sum = scan_sum - NUM_REQ;
      end
      scan_idx = SRC_W'(scan_sum);
      if (!grant_found && req_valid_i[scan_idx]) begin
        grant_found = 1'b1;
        grant_idx   = scan_idx;
      end
    end
  end

  // Per-requester ready: winner in IDLE, owner only in LOCKED, never while the slot is stalled.
  always_comb begin
    req_ready_o = '0;
    if (!srst_i && reg_free) begin
      if (state_q == ST_IDLE) begin
        if (grant_found) begin
          req_ready_o[grant_idx] = 1'b1;
        end
      end else begin
        req_ready_o[owner_q] = 1'b1;
      end
    end
  end

  assign acc_valid = |(req_valid_i & req_ready_o);
  assign acc_idx   = (state_q == ST_IDLE) ? grant_idx : owner_q;

  // Payload select for the accepted requester.
  always_comb begin
    acc_flit = '0;
    acc_last = 1'b0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      if (acc_idx == SRC_W'(k)) begin
        acc_flit = req_flit_i[k*FLIT_W +: FLIT_W];
        acc_last = req_last_i[k];
      end
    end
  end

  assign wd_fire = acc_valid && (state_q == ST_LOCKED) && (beat_cnt_q == WD_CNT) && !acc_last;

  // Next-state: arbitration FSM, pointer, owner, beat counter, sticky error.
  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    owner_d    = owner_q;
    beat_cnt_d = beat_cnt_q;
    err_d      = err_q;
    if (err_clr_i) begin
      err_d = 1'b0;
    end
    if (wd_fire) begin
      err_d = 1'b1;
    end
    if (acc_valid) begin
      if (state_q == ST_IDLE) begin
        if (acc_last) begin
          ptr_d = wrap_inc(grant_idx);
        end else begin
          state_d    = ST_LOCKED;
          owner_d    = grant_idx;
          beat_cnt_d = CNT_W'(1);
        end
      end else begin
        if (acc_last || wd_fire) begin
          state_d    = ST_IDLE;
          ptr_d      = wrap_inc(owner_q);
          beat_cnt_d = '0;
        end else begin
          beat_cnt_d = beat_cnt_q + CNT_W'(1);
        end
      end
    end
  end

  // Next-state: output slot loads on accept, drains when the link takes it.
  always_comb begin
    out_valid_d = out_valid_q;
    out_flit_d  = out_flit_q;
    out_last_d  = out_last_q;
    out_src_d   = out_src_q;
    if (acc_valid) begin
      out_valid_d = 1'b1;
      out_flit_d  = acc_flit;
      out_last_d  = acc_last | wd_fire;
      out_src_d   = acc_idx;
    end else if (out_ready_i) begin
      out_valid_d = 1'b0;
    end
    busy_d = (state_d == ST_LOCKED) | out_valid_d;
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (srst_i) begin
      state_q     <= ST_IDLE;
      ptr_q       <= '0;
      owner_q     <= '0;
      beat_cnt_q  <= '0;
      err_q       <= 1'b0;
      busy_q      <= 1'b0;
      out_valid_q <= 1'b0;
      out_flit_q  <= '0;
      out_last_q  <= 1'b0;
      out_src_q   <= '0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      owner_q     <= owner_d;
      beat_cnt_q  <= beat_cnt_d;
      err_q       <= err_d;
      busy_q      <= busy_d;
      out_valid_q <= out_valid_d;
      out_flit_q  <= out_flit_d;
      out_last_q  <= out_last_d;
      out_src_q   <= out_src_d;
    end
  end

  assign out_valid_o = out_valid_q;
  assign out_flit_o  = out_flit_q;
  assign out_last_o  = out_last_q;
  assign out_src_o   = out_src_q;
  assign busy_o      = busy_q;
  assign err_o       = err_q;

endmodule

// File: tb/tb_axi_grid_xni_link_arb.sv
// Directed bench for axi_grid_xni_link_arb: reset, round-robin, packet lock,
// backpressure, watchdog with sticky error, and reset mid-packet.
module tb_axi_grid_xni_link_arb;

  localparam int unsigned NUM_REQ   = 4;
  localparam int unsigned FLIT_W    = 16;
  localparam int unsigned MAX_BEATS = 8;
  localparam int unsigned SRC_W     = 2;

  logic                      clk = 1'b0;
  logic                      srst;
  logic [NUM_REQ-1:0]        req_valid;
  logic [NUM_REQ-1:0]        req_last;
  logic [NUM_REQ-1:0]        req_ready;
  logic [FLIT_W-1:0]         flit_a [NUM_REQ];
  logic [NUM_REQ*FLIT_W-1:0] req_flit;
  logic                      out_valid;
  logic [FLIT_W-1:0]         out_flit;
  logic                      out_last;
  logic [SRC_W-1:0]          out_src;
  logic                      out_ready;
  logic                      busy;
  logic                      err;
  logic                      err_clr;

  int n_assert = 0;
  int n_fail   = 0;
  int mon_base = 0;
  logic [FLIT_W-1:0] link_q [$];

  assign req_flit = {flit_a[3], flit_a[2], flit_a[1], flit_a[0]};

  axi_grid_xni_link_arb #(
    .NUM_REQ  (NUM_REQ),
    .FLIT_W   (FLIT_W),
    .MAX_BEATS(MAX_BEATS),
    .SRC_W    (SRC_W)
  ) dut (
    .clk_i      (clk),
    .srst_i     (srst),
    .req_valid_i(req_valid),
    .req_flit_i (req_flit),
    .req_last_i (req_last),
    .req_ready_o(req_ready),
    .out_valid_o(out_valid),
    .out_flit_o (out_flit),
    .out_last_o (out_last),
    .out_src_o  (out_src),
    .out_ready_i(out_ready),
    .busy_o     (busy),
    .err_o      (err),
    .err_clr_i  (err_clr)
  );

  always #5 clk = ~clk;

  // Record every flit the link actually takes.
  always @(posedge clk) begin
    if (out_valid && out_ready) begin
      link_q.push_back(out_flit);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    srst      = 1'b1;
    req_valid = '0;
    req_last  = '0;
    out_ready = 1'b1;
    err_clr   = 1'b0;
    for (int k = 0; k < 4; k++) flit_a[k] = '0;

    // ---- reset ----
    step();
    flit_a[2] = 16'h2001; req_valid = 4'b0100; req_last = 4'b0100;
    #1;
    chk("rst_ready", 32'(req_ready), 32'h0);
    step();
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_flit",  32'(out_flit),  32'h0);
    chk("rst_last",  32'(out_last),  32'd0);
    chk("rst_src",   32'(out_src),   32'd0);
    chk("rst_err",   32'(err),       32'd0);
    chk("rst_busy",  32'(busy),      32'd0);
    srst = 1'b0; req_valid = '0; req_last = '0;
    repeat (3) step();
    chk("idle_valid", 32'(out_valid), 32'd0);
    chk("idle_busy",  32'(busy),      32'd0);
    chk("idle_flit",  32'(out_flit),  32'h0);

    // ---- single beat from requester 2 ----
    req_valid = 4'b0100; req_last = 4'b0100;
    #1;
    chk("r2_ready", 32'(req_ready), 32'h4);
    step();
    req_valid = '0; req_last = '0;
    chk("r2_valid", 32'(out_valid), 32'd1);
    chk("r2_flit",  32'(out_flit),  32'h2001);
    chk("r2_last",  32'(out_last),  32'd1);
    chk("r2_src",   32'(out_src),   32'd2);
    chk("r2_busy",  32'(busy),      32'd1);
    step();
    chk("r2_drain_valid", 32'(out_valid), 32'd0);
    chk("r2_drain_hold",  32'(out_flit),  32'h2001);
    chk("r2_drain_busy",  32'(busy),      32'd0);

    // ---- round-robin, ptr starts at 3 ----
    flit_a[0] = 16'h0A00; flit_a[1] = 16'h1A00; flit_a[2] = 16'h2A00; flit_a[3] = 16'h3A00;
    req_valid = 4'hF; req_last = 4'hF;
    for (int i = 0; i < 8; i++) begin
      step();
      chk("rr_valid", 32'(out_valid), 32'd1);
      chk("rr_src",   32'(out_src),   32'((3 + i) % 4));
      chk("rr_flit",  32'(out_flit),  32'((3 + i) % 4) * 32'h1000 + 32'h0A00);
    end
    req_valid = '0; req_last = '0;
    step();
    chk("rr_drain", 32'(out_valid), 32'd0);

    // ---- packet lock: requester 1 four beats, requester 0 waiting ----
    flit_a[1] = 16'h1101; req_valid = 4'b0010;
    #1;
    chk("lk_b1_ready", 32'(req_ready), 32'h2);
    step();
    chk("lk_b1_flit", 32'(out_flit), 32'h1101);
    chk("lk_b1_last", 32'(out_last), 32'd0);
    flit_a[0] = 16'h0001; flit_a[1] = 16'h1102; req_valid = 4'b0011; req_last = 4'b0001;
    #1;
    chk("lk_b2_r0", 32'(req_ready[0]), 32'd0);
    step();
    chk("lk_b2_flit", 32'(out_flit), 32'h1102);
    req_valid = 4'b0001;
    #1;
    chk("lk_gap_r0", 32'(req_ready[0]), 32'd0);
    step();
    chk("lk_gap_valid", 32'(out_valid), 32'd0);
    chk("lk_gap_busy",  32'(busy),      32'd1);
    chk("lk_gap_r0b",   32'(req_ready[0]), 32'd0);
    step();
    chk("lk_gap2_valid", 32'(out_valid), 32'd0);
    chk("lk_gap2_r0",    32'(req_ready[0]), 32'd0);
    flit_a[1] = 16'h1103; req_valid = 4'b0011;
    #1;
    chk("lk_b3_r0", 32'(req_ready[0]), 32'd0);
    step();
    chk("lk_b3_flit", 32'(out_flit), 32'h1103);
    flit_a[1] = 16'h1104; req_last = 4'b0011;
    #1;
    chk("lk_b4_r0", 32'(req_ready[0]), 32'd0);
    step();
    chk("lk_b4_flit", 32'(out_flit), 32'h1104);
    chk("lk_b4_last", 32'(out_last), 32'd1);
    chk("lk_b4_src",  32'(out_src),  32'd1);
    req_valid = 4'b0001;
    #1;
    chk("lk_r0_ready", 32'(req_ready), 32'h1);
    step();
    chk("lk_r0_src",  32'(out_src),  32'd0);
    chk("lk_r0_flit", 32'(out_flit), 32'h0001);
    req_valid = '0; req_last = '0;
    step();
    chk("lk_drain", 32'(out_valid), 32'd0);

    // ---- backpressure mid-packet, requester 1 six beats ----
    mon_base = link_q.size();
    flit_a[1] = 16'h1201; req_valid = 4'b0010;
    step();
    flit_a[1] = 16'h1202;
    step();
    flit_a[1] = 16'h1203; out_ready = 1'b0;
    #1;
    chk("bp_ready0", 32'(req_ready), 32'h0);
    for (int i = 0; i < 5; i++) begin
      step();
      chk("bp_hold_flit",  32'(out_flit),  32'h1202);
      chk("bp_hold_valid", 32'(out_valid), 32'd1);
      chk("bp_hold_ready", 32'(req_ready), 32'h0);
    end
    out_ready = 1'b1;
    #1;
    chk("bp_resume_ready", 32'(req_ready), 32'h2);
    step();
    chk("bp_b3_flit", 32'(out_flit), 32'h1203);
    flit_a[1] = 16'h1204;
    step();
    flit_a[1] = 16'h1205;
    step();
    flit_a[1] = 16'h1206; req_last = 4'b0010;
    step();
    chk("bp_b6_last", 32'(out_last), 32'd1);
    req_valid = '0; req_last = '0;
    step();
    chk("bp_drain", 32'(out_valid), 32'd0);
    chk("bp_count", 32'(link_q.size() - mon_base), 32'd6);
    for (int i = 0; i < 6; i++) begin
      chk("bp_seq", 32'(link_q[mon_base + i]), 32'h1201 + 32'(i));
    end

    // ---- watchdog: requester 3 runs past MAX_BEATS ----
    req_valid = 4'b1000; req_last = '0;
    for (int b = 1; b <= 8; b++) begin
      flit_a[3] = 16'h3300 + 16'(b);
      step();
      chk("wd_flit", 32'(out_flit), 32'h3300 + 32'(b));
      if (b < 8) begin
        chk("wd_last_early", 32'(out_last), 32'd0);
        chk("wd_err_early",  32'(err),      32'd0);
      end
    end
    chk("wd_last8", 32'(out_last), 32'd1);
    chk("wd_err8",  32'(err),      32'd1);
    chk("wd_src8",  32'(out_src),  32'd3);
    flit_a[3] = 16'h3309; flit_a[0] = 16'h0002; req_valid = 4'b1001; req_last = 4'b0001;
    #1;
    chk("wd_rearb_ready", 32'(req_ready), 32'h1);
    step();
    chk("wd_r0_src",  32'(out_src),  32'd0);
    chk("wd_r0_flit", 32'(out_flit), 32'h0002);
    chk("wd_sticky",  32'(err),      32'd1);
    req_valid = 4'b1000; req_last = '0;
    #1;
    chk("wd_b9_ready", 32'(req_ready), 32'h8);
    step();
    chk("wd_b9_flit", 32'(out_flit), 32'h3309);
    chk("wd_b9_last", 32'(out_last), 32'd0);
    flit_a[3] = 16'h330A; req_last = 4'b1000;
    step();
    chk("wd_b10_flit", 32'(out_flit), 32'h330A);
    chk("wd_b10_last", 32'(out_last), 32'd1);
    req_valid = '0; req_last = '0; err_clr = 1'b1;
    step();
    chk("wd_clr", 32'(err), 32'd0);
    err_clr = 1'b0;

    // ---- set wins over clear: requester 2 runaway with clear on beat 8 ----
    req_valid = 4'b0100; req_last = '0;
    for (int b = 1; b <= 8; b++) begin
      flit_a[2] = 16'h2300 + 16'(b);
      if (b == 8) err_clr = 1'b1;
      step();
    end
    chk("sw_src",  32'(out_src),  32'd2);
    chk("sw_last", 32'(out_last), 32'd1);
    chk("sw_err",  32'(err),      32'd1);
    req_valid = '0;
    step();
    chk("sw_clr", 32'(err), 32'd0);
    err_clr = 1'b0;

    // ---- reset mid-packet: requester 1, ptr currently 3 ----
    flit_a[1] = 16'h1301; req_valid = 4'b0010;
    step();
    flit_a[1] = 16'h1302;
    step();
    chk("mr_b2_flit", 32'(out_flit), 32'h1302);
    flit_a[1] = 16'h1303; srst = 1'b1;
    #1;
    chk("mr_rst_ready", 32'(req_ready), 32'h0);
    step();
    chk("mr_valid", 32'(out_valid), 32'd0);
    chk("mr_busy",  32'(busy),      32'd0);
    chk("mr_flit",  32'(out_flit),  32'h0);
    srst = 1'b0;
    flit_a[1] = 16'h1401; flit_a[3] = 16'h3401; req_valid = 4'b1010; req_last = 4'b1010;
    #1;
    chk("mr_ptr0_ready", 32'(req_ready), 32'h2);
    step();
    chk("mr_src1",  32'(out_src),  32'd1);
    chk("mr_flit1", 32'(out_flit), 32'h1401);
    req_valid = 4'b1000;
    #1;
    chk("mr_r3_ready", 32'(req_ready), 32'h8);
    step();
    chk("mr_src3",  32'(out_src),  32'd3);
    chk("mr_flit3", 32'(out_flit), 32'h3401);
    req_valid = '0; req_last = '0;
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
